// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with req/ack data-memory handshake, lane steering and MEM/WB registers
module mem_access_stage #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_op,
    input  logic              read_not_write,
    input  logic [1:0]        size,
    input  logic              mem_sign_extend,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_we,
    input  logic [4:0]        rd_loc,
    input  logic [1:0]        rw_d,
    input  logic [31:0]       pc,
    input  logic [31:0]       insn,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic              r_we_out,
    output logic [4:0]        rd_loc_out,
    output logic [1:0]        rw_d_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       insn_out,
    output logic [ADDR_W-1:0] alu_out,
    output logic [DATA_W-1:0] load_data,
    output logic [1:0]        exc_out
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [OFF_W-1:0]        off;
    logic [3:0]              nb;
    logic                    aligned, last, ack, timeout;
    logic [1:0]              exc;
    logic [6:0]              sh_l, sh_r;
    logic [DATA_W-1:0]       lj, ext;
    logic signed [DATA_W-1:0] sxt;

    assign off     = address[OFF_W-1:0];
    assign nb      = size == 2'd2 ? 4'd1 : size == 2'd1 ? 4'd2 : size == 2'd0 ? 4'd4 : 4'(NB);
    assign aligned = size == 2'd2 ? 1'b1 : size == 2'd1 ? ~address[0] :
                     size == 2'd0 ? address[1:0] == 2'b00 : (DATA_W == 64 && off == '0);
    // reset gates the request combinationally so an abandoned access drops at once
    assign mem_req   = rst_n & in_valid & mem_op & aligned;
    assign last      = state == WAIT && cnt == CNT_W'(MAX_WAIT - 1);
    assign ack       = mem_req & mem_ack;
    assign timeout   = mem_req & ~mem_ack & last;
    assign stall_out = mem_req & ~mem_ack & ~last;
    assign exc       = (in_valid & mem_op & ~aligned) ? 2'b01 : timeout ? 2'b10 : 2'b00;
    assign mem_we    = ~read_not_write;
    assign mem_addr  = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // lane 0 is the most significant byte, so the enable mask is built top-down
    assign mem_be    = mem_req ? ~({NB{1'b1}} >> nb) >> off : '0;
    assign mem_wdata = size == 2'd2 ? {NB{data_in[7:0]}} : size == 2'd1 ? {(NB/2){data_in[15:0]}} :
                       size == 2'd0 ? {(NB/4){data_in[31:0]}} : data_in;
    // left-justify the addressed bytes, then a single right shift both aligns and extends
    assign sh_l = 7'({off, 3'b000});
    assign sh_r = 7'(DATA_W) - {nb, 3'b000};
    assign lj   = mem_rdata << sh_l;
    assign sxt  = $signed(lj) >>> sh_r;
    assign ext  = mem_sign_extend ? sxt : lj >> sh_r;

    // handshake FSM: remain in WAIT while stalled, counting wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stall_out ? WAIT : IDLE;
            cnt   <= (state == WAIT && stall_out) ? cnt + CNT_W'(1) : '0;
        end
    end

    // MEM/WB register: bubble on stalled edges, capture otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            r_we_out   <= 1'b0;
            rd_loc_out <= '0;
            rw_d_out   <= '0;
            pc_out     <= '0;
            insn_out   <= '0;
            alu_out    <= '0;
            load_data  <= '0;
            exc_out    <= '0;
        end else if (stall_out) begin
            out_valid <= 1'b0;
            r_we_out  <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            r_we_out   <= r_we & in_valid & (exc == 2'b00);
            rd_loc_out <= rd_loc;
            rw_d_out   <= rw_d;
            pc_out     <= pc;
            insn_out   <= insn;
            alu_out    <= address;
            exc_out    <= exc;
            if (ack & read_not_write) load_data <= ext;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench for mem_access_stage against a byte-array memory model
module tb_mem_access_stage;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 0, mem_op = 0, read_not_write = 0, mem_sign_extend = 0, r_we = 0;
    logic [1:0]  size = 0, rw_d = 0;
    logic [4:0]  rd_loc = 0;
    logic [31:0] address = 0, data_in = 0, pc = 0, insn = 0, mem_rdata = 0;
    logic        mem_ack = 0;
    logic        stall_out, mem_req, mem_we, out_valid, r_we_out;
    logic [31:0] mem_addr, mem_wdata, pc_out, insn_out, alu_out, load_data;
    logic [3:0]  mem_be;
    logic [4:0]  rd_loc_out;
    logic [1:0]  rw_d_out, exc_out;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_op(mem_op),
        .read_not_write(read_not_write), .size(size), .mem_sign_extend(mem_sign_extend),
        .address(address), .data_in(data_in), .r_we(r_we), .rd_loc(rd_loc), .rw_d(rw_d),
        .pc(pc), .insn(insn), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .r_we_out(r_we_out),
        .rd_loc_out(rd_loc_out), .rw_d_out(rw_d_out), .pc_out(pc_out), .insn_out(insn_out),
        .alu_out(alu_out), .load_data(load_data), .exc_out(exc_out)
    );

    typedef struct {
        logic        r_we;
        logic [4:0]  rd;
        logic [1:0]  rw_d;
        logic [31:0] pc, insn, alu, ld;
        logic [1:0]  exc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  bmem [0:255];
    logic [31:0] last_ld = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rd_word(logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {bmem[b], bmem[b + 8'd1], bmem[b + 8'd2], bmem[b + 8'd3]};
    endfunction

    function automatic logic [31:0] load_model(logic [31:0] a, int n, logic sx);
        logic [63:0] v;
        logic [7:0]  i8;
        v = 0;
        for (int i = 0; i < n; i++) begin
            i8 = a[7:0] + 8'(i);
            v  = (v << 8) | 64'(bmem[i8]);
        end
        if (sx && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    // monitor: every valid MEM/WB output must match the oldest expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
            else begin
                e = sb.pop_front();
                chk("r_we_out", 32'(r_we_out), 32'(e.r_we));
                chk("rd_loc_out", 32'(rd_loc_out), 32'(e.rd));
                chk("rw_d_out", 32'(rw_d_out), 32'(e.rw_d));
                chk("pc_out", pc_out, e.pc);
                chk("insn_out", insn_out, e.insn);
                chk("alu_out", alu_out, e.alu);
                chk("load_data", load_data, e.ld);
                chk("exc_out", 32'(exc_out), 32'(e.exc));
            end
        end
    end

    task automatic run_insn(input logic v, input logic mo, input logic rnw, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a, input logic [31:0] d, input int dly);
        int n, off, cyc;
        logic al, acc, tmo;
        logic [3:0] ebe;
        logic [31:0] ewd;
        logic [7:0] i8;
        exp_t e;
        in_valid = v; mem_op = mo; read_not_write = rnw; size = sz; mem_sign_extend = sx;
        address = a; data_in = d; r_we = 1'($urandom); rd_loc = 5'($urandom);
        rw_d = 2'($urandom); pc = $urandom; insn = $urandom;
        n   = sz == 2 ? 1 : sz == 1 ? 2 : sz == 0 ? 4 : 8;
        off = int'(a[1:0]);
        al  = sz != 3 && (off % n) == 0;
        acc = v && mo && al;
        tmo = acc && (dly < 0 || dly > MAX_WAIT);
        cyc = !acc ? 1 : tmo ? MAX_WAIT + 1 : dly + 1;
        ebe = 0;
        ewd = 0;
        for (int k = 0; k < 4; k++) begin
            ebe[3-k] = k >= off && k < off + n;
            ewd[31-8*k -: 8] = d[8*(n-1-(k % n)) +: 8];
        end
        for (int c = 0; c < cyc; c++) begin
            mem_ack   = acc ? (c == dly) : 1'($urandom);
            mem_rdata = rd_word(a);
            @(negedge clk);
            chk("stall_out", 32'(stall_out), 32'(acc && c < cyc - 1));
            chk("mem_req", 32'(mem_req), 32'(acc));
            if (acc && c >= 1) chk("bubble", 32'(out_valid), 0);
            if (acc && c == 0) begin
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_we", 32'(mem_we), 32'(!rnw));
                chk("mem_be", 32'(mem_be), 32'(ebe));
                if (!rnw) chk("mem_wdata", mem_wdata, ewd);
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 0;
        if (acc && !tmo && rnw) last_ld = load_model(a, n, sx);
        if (acc && !tmo && !rnw)
            for (int k = 0; k < n; k++) begin
                i8 = a[7:0] + 8'(k);
                bmem[i8] = d[8*(n-1-k) +: 8];
            end
        if (v) begin
            e.exc  = (mo && !al) ? 2'b01 : tmo ? 2'b10 : 2'b00;
            e.r_we = r_we && e.exc == 2'b00;
            e.rd = rd_loc; e.rw_d = rw_d; e.pc = pc; e.insn = insn; e.alu = a; e.ld = last_ld;
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [1:0] sz;
        logic [31:0] a;
        int r, n;
        for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
        in_valid = 1; mem_op = 1; read_not_write = 1; address = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_exc_out", 32'(exc_out), 0);
        chk("rst_pc_out", pc_out, 0);
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        run_insn(1, 1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0);
        run_insn(1, 1, 0, 2, 0, 32'h103, 32'h000000A5, 0);
        bmem[8'h00] = 8'h12; bmem[8'h01] = 8'h80; bmem[8'h02] = 8'h34; bmem[8'h03] = 8'h56;
        run_insn(1, 1, 1, 2, 1, 32'h101, 0, 0);
        run_insn(1, 1, 1, 2, 0, 32'h101, 0, 0);
        run_insn(1, 1, 1, 1, 1, 32'h101, 0, 0);
        run_insn(1, 1, 1, 0, 1, 32'h100, 0, 3);
        run_insn(1, 1, 1, 0, 0, 32'h104, 0, -1);
        run_insn(0, 1, 1, 0, 0, 32'h108, 0, 0);
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom % 10);
            sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
            n  = sz == 2 ? 1 : sz == 1 ? 2 : 4;
            a  = $urandom;
            if ($urandom % 4 != 0) a = a & ~32'(n - 1);
            run_insn(($urandom % 8) != 0, ($urandom % 5) != 0, 1'($urandom), sz, 1'($urandom),
                     a, $urandom, int'($urandom_range(0, 7)) - 1);
        end
        run_insn(0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1; mem_op = 1; read_not_write = 1; size = 0; address = 32'h200; mem_ack = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("midwait_mem_req", 32'(mem_req), 0);
        chk("midwait_stall", 32'(stall_out), 0);
        chk("midwait_out_valid", 32'(out_valid), 0);
        chk("midwait_load_data", load_data, 0);
        chk("midwait_exc_out", 32'(exc_out), 0);
        sb.delete();
        last_ld = 0;
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++)
            run_insn(1, 1, 1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                     $urandom & 32'hFFFF_FFFC, $urandom, int'($urandom_range(0, 6)) - 1);
        run_insn(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
